multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the MIPS core: it replaces the single-cycle combinational decoder. Each instruction is broken into FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps, and the controller drives the shared-ALU, single-memory datapath one step per clock. A `mem_ready` handshake lets it stall on slow memory. Unsupported encodings put it into a sticky halt.

## Interface
- No parameters. Widths are fixed by the MIPS-I encoding.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_en`  out  1  PC load enable: `pc_write | (pc_write_cond & zero)`.
- `iord`  out  1  memory address source: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `ir_write`  out  1  IR load.
- `reg_write`  out  1  register file write.
- `reg_dst`  out  1  destination select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- `alu_src_a`  out  1  ALU A operand: 0 = PC, 1 = A.
- `alu_src_b`  out  2  ALU B operand: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `pc_source`  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `alu_ctrl`  out  4  ALU operation code.
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction.
- `halted`  out  1  high in HALT.

## Operation
- **States:** FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB, HALT. The state is registered; outputs are a Moore decode of the state.
- **FETCH:** `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, ALU add, `pc_source`=00.
  - `ir_write` and `pc_write` are asserted only when `mem_ready`=1.
  - When `mem_ready`=1, go to DECODE; otherwise stay in FETCH.
- **DECODE:** `alu_src_a`=0, `alu_src_b`=11, ALU add (branch target into ALUOut). Next state by opcode:
  - 0x00 → R_EXEC, if `funct` ∈ {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt}; any other funct → HALT.
  - 0x23 (lw) or 0x2B (sw) → MEM_ADDR.
  - 0x04 (beq) → BRANCH.
  - 0x02 (j) → JUMP.
  - 0x08 (addi) → ADDI_EX.
  - Any other opcode → HALT.
- **MEM_ADDR:** `alu_src_a`=1, `alu_src_b`=10, add. Next state is MEM_READ for lw, MEM_WRITE for sw.
- **MEM_READ:** `mem_read`=1, `iord`=1. Stay until `mem_ready`=1, then go to MEM_WB.
- **MEM_WB:** `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1, `instr_done`=1. Next state FETCH.
- **MEM_WRITE:** `mem_write`=1, `iord`=1. Stay until `mem_ready`=1; on the `mem_ready` cycle `instr_done`=1 and next state is FETCH.
- **R_EXEC:** `alu_src_a`=1, `alu_src_b`=00, ALU function from `funct`. Next state R_WB.
- **R_WB:** `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1. Next state FETCH.
- **BRANCH:** `alu_src_a`=1, `alu_src_b`=00, sub, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1. Next state FETCH.
- **JUMP:** `pc_write`=1, `pc_source`=10, `instr_done`=1. Next state FETCH.
- **ADDI_EX:** `alu_src_a`=1, `alu_src_b`=10, add. Next state ADDI_WB.
- **ADDI_WB:** `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1. Next state FETCH.
- **HALT:** `halted`=1, all enables 0. Sticky until `reset` goes low.
- **ALU codes (`alu_ctrl`):** add 0010, sub 0110, and 0000, or 0001, slt 0111.
- **Unlisted outputs are 0 in every state.**

## Timing
- **While `reset`=0:** state is forced to FETCH and every output is forced to 0, independent of `clk`. This holds even mid-instruction or during a stall.
- **After reset release:** the first edge with `mem_ready`=1 completes FETCH.
- **Latency with `mem_ready` held 1:** R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
- **Stalls:** each cycle with `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. All outputs are held stable during the stall.
- **Handshake:** `mem_ready` is sampled only in FETCH, MEM_READ and MEM_WRITE, and ignored elsewhere.
- **`instr_done`:** exactly one cycle per retired instruction; never asserted for the instruction that goes to HALT.
- **`pc_en` for beq:** combinational from `zero` in BRANCH. No other state gates the PC on `zero`.

## Structure
- **Package `mc_ctrl_pkg`:**
  - state encoding, 4 bits, FETCH = 0;
  - opcode constants;
  - funct constants;
  - ALU control codes;
  - `alu_src_b` and `pc_source` encodings.
- **Sub-module `alu_control`:** combinational; (FSM ALU request, `funct`) → `alu_ctrl`. Instantiated once.

## Test plan
- **Reset:** drive `reset`=0 mid-way through MEM_READ of a lw → all outputs read 0 at once; after release the state is FETCH and `mem_read`=1.
- **add:** opcode 0x00, funct 0x20, `mem_ready`=1 → `instr_done` on cycle 4; R_WB shows `reg_write`=1, `reg_dst`=1, `alu_ctrl`=0010 in R_EXEC.
- **lw with stall:** opcode 0x23, `mem_ready` low for 3 cycles in MEM_READ → `instr_done` on cycle 8; `iord`=1 held throughout.
- **beq:** opcode 0x04 → `pc_en`=1 in BRANCH when `zero`=1, `pc_en`=0 when `zero`=0; 3 cycles either way.
- **Sequence:** sw, j, addi back-to-back with `mem_ready`=1 → `instr_done` pulses at cycles 4, 7 and 11.
- **Illegal encodings:** opcode 0x3F, or opcode 0x00 with funct 0x00 → HALT after DECODE; `halted`=1 and no strobes for 20 cycles until reset.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control FSM.
// Provides the state encoding, MIPS-I opcode/funct constants, ALU control
// codes, datapath mux encodings and the packed control word the FSM emits.
package mc_ctrl_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned STATE_W    = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_HALT      = 4'd12
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;

  // What the FSM asks of the ALU; FUNCT defers to the instruction's funct field.
  typedef enum logic [1:0] {
    ALU_REQ_NONE  = 2'b00,
    ALU_REQ_ADD   = 2'b01,
    ALU_REQ_SUB   = 2'b10,
    ALU_REQ_FUNCT = 2'b11
  } alu_req_e;

  typedef enum logic [1:0] {
    SRCB_REG      = 2'b00,
    SRCB_FOUR     = 2'b01,
    SRCB_IMM      = 2'b10,
    SRCB_IMM_SHL2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_e;

  // Per-state control word produced by the FSM decode.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    pc_source_e pc_source;
    alu_req_e   alu_req;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

  // True for the R-type funct codes the datapath supports.
  function automatic logic is_rtype_funct(input logic [FUNCT_W-1:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and the datapath.
// master: controller (reads IR fields, zero flag, mem_ready; drives controls).
// slave : datapath/memory side (drives IR fields and status; reads controls).
interface multicycle_ctrl_if;
  import mc_ctrl_pkg::*;

  logic [OP_W-1:0]       opcode;
  logic [FUNCT_W-1:0]    funct;
  logic                  zero;
  logic                  mem_ready;

  logic                  pc_en;
  logic                  iord;
  logic                  mem_read;
  logic                  mem_write;
  logic                  ir_write;
  logic                  reg_write;
  logic                  reg_dst;
  logic                  mem_to_reg;
  logic                  alu_src_a;
  logic [1:0]            alu_src_b;
  logic [1:0]            pc_source;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  instr_done;
  logic                  halted;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_ctrl,
           instr_done, halted
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_ctrl,
           instr_done, halted
  );

endinterface

// File: rtl/multicycle_ctrl_alu_control.sv
// ALU operation decoder: maps the FSM's ALU request and the R-type funct
// field onto the 4-bit ALU control code. Purely combinational.
//   alu_req  in  FSM request (none/add/sub/by-funct)
//   funct    in  IR[5:0]
//   alu_ctrl out ALU operation code
module alu_control
  import mc_ctrl_pkg::*;
(
  input  alu_req_e              alu_req,
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ALU_CTRL_W-1:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_AND;
    case (alu_req)
      ALU_REQ_ADD: alu_ctrl = ALU_ADD;
      ALU_REQ_SUB: alu_ctrl = ALU_SUB;
      ALU_REQ_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM. Steps each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, stalls on mem_ready in the memory
// states and parks in a sticky HALT on unsupported encodings.
//   clk    in  system clock
//   reset  in  asynchronous active-low reset (forces FETCH and zero outputs)
//   bus    master side of multicycle_ctrl_if (IR fields, zero, mem_ready in;
//          datapath controls, instr_done, halted out)
module multicycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  state_e                state_q;
  state_e                state_d;
  ctrl_t                 ctrl_c;
  ctrl_t                 ctrl_o;
  logic [ALU_CTRL_W-1:0] alu_ctrl_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore control decode
  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.alu_req   = ALU_REQ_ADD;
        ctrl_c.pc_source = PCSRC_ALU;
        // IR and PC only load on the cycle the fetch actually completes
        if (bus.mem_ready) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          state_d         = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut
        ctrl_c.alu_src_b = SRCB_IMM_SHL2;
        ctrl_c.alu_req   = ALU_REQ_ADD;
        case (bus.opcode)
          OP_RTYPE: state_d = is_rtype_funct(bus.funct) ? S_R_EXEC : S_HALT;
          OP_LW,
          OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
          OP_ADDI:  state_d = S_ADDI_EX;
          default:  state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_req   = ALU_REQ_ADD;
        state_d          = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.iord     = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.iord      = 1'b1;
        // Store retires on the cycle memory accepts it
        if (bus.mem_ready) begin
          ctrl_c.instr_done = 1'b1;
          state_d           = S_FETCH;
        end
      end
      S_R_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_REG;
        ctrl_c.alu_req   = ALU_REQ_FUNCT;
        state_d          = S_R_WB;
      end
      S_R_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.reg_dst    = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = SRCB_REG;
        ctrl_c.alu_req       = ALU_REQ_SUB;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCSRC_ALUOUT;
        ctrl_c.instr_done    = 1'b1;
        state_d              = S_FETCH;
      end
      S_JUMP: begin
        ctrl_c.pc_write   = 1'b1;
        ctrl_c.pc_source  = PCSRC_JUMP;
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_ADDI_EX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_req   = ALU_REQ_ADD;
        state_d          = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_HALT: begin
        ctrl_c.halted = 1'b1;
        state_d       = S_HALT;
      end
      default: begin
        // Unreachable encodings are treated as a fault
        state_d = S_HALT;
      end
    endcase
  end

  alu_control u_alu_control (
    .alu_req  (ctrl_c.alu_req),
    .funct    (bus.funct),
    .alu_ctrl (alu_ctrl_c)
  );

  // Outputs drop to zero the moment reset is asserted, without waiting for clk
  assign ctrl_o = reset ? ctrl_c : '0;

  assign bus.pc_en      = ctrl_o.pc_write | (ctrl_o.pc_write_cond & bus.zero);
  assign bus.iord       = ctrl_o.iord;
  assign bus.mem_read   = ctrl_o.mem_read;
  assign bus.mem_write  = ctrl_o.mem_write;
  assign bus.ir_write   = ctrl_o.ir_write;
  assign bus.reg_write  = ctrl_o.reg_write;
  assign bus.reg_dst    = ctrl_o.reg_dst;
  assign bus.mem_to_reg = ctrl_o.mem_to_reg;
  assign bus.alu_src_a  = ctrl_o.alu_src_a;
  assign bus.alu_src_b  = ctrl_o.alu_src_b;
  assign bus.pc_source  = ctrl_o.pc_source;
  assign bus.alu_ctrl   = reset ? alu_ctrl_c : '0;
  assign bus.instr_done = ctrl_o.instr_done;
  assign bus.halted     = ctrl_o.halted;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected control words
// are queued from the state tables as stimulus is planned, observed words are
// queued as the DUT produces them, and each test task drains and compares.
module tb_multicycle_ctrl;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_SLT = 4'b0111;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc;
  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];
  string       name_q[$];
  int          done_q[$];

  // {pc_en,iord,mem_read,mem_write,ir_write,reg_write,reg_dst,mem_to_reg,
  //  alu_src_a,alu_src_b[1:0],pc_source[1:0],alu_ctrl[3:0],instr_done,halted}
  function automatic logic [18:0] mk(input logic pce, io, mr, mw, irw, rw, rd, m2r, asa,
                                     input logic [1:0] asb, input logic [1:0] pcs,
                                     input logic [3:0] alu, input logic done, input logic hlt);
    return {pce, io, mr, mw, irw, rw, rd, m2r, asa, asb, pcs, alu, done, hlt};
  endfunction

  function automatic logic [18:0] obs();
    return {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
            bus.alu_src_b, bus.pc_source, bus.alu_ctrl, bus.instr_done, bus.halted};
  endfunction

  function automatic logic [18:0] e_fetch(input logic r);
    return mk(r,0,1,0,r,0,0,0,0,2'b01,2'b00,A_ADD,0,0);
  endfunction
  function automatic logic [18:0] e_decode();
    return mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,A_ADD,0,0);
  endfunction
  function automatic logic [18:0] e_memaddr();
    return mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,A_ADD,0,0);
  endfunction
  function automatic logic [18:0] e_memread();
    return mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,A_AND,0,0);
  endfunction
  function automatic logic [18:0] e_memwb();
    return mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,A_AND,1,0);
  endfunction
  function automatic logic [18:0] e_memwrite(input logic r);
    return mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,A_AND,r,0);
  endfunction
  function automatic logic [18:0] e_rexec(input logic [3:0] alu);
    return mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,alu,0,0);
  endfunction
  function automatic logic [18:0] e_rwb();
    return mk(0,0,0,0,0,1,1,0,0,2'b00,2'b00,A_AND,1,0);
  endfunction
  function automatic logic [18:0] e_branch(input logic z);
    return mk(z,0,0,0,0,0,0,0,1,2'b00,2'b01,A_SUB,1,0);
  endfunction
  function automatic logic [18:0] e_jump();
    return mk(1,0,0,0,0,0,0,0,0,2'b00,2'b10,A_AND,1,0);
  endfunction
  function automatic logic [18:0] e_addiex();
    return mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,A_ADD,0,0);
  endfunction
  function automatic logic [18:0] e_addiwb();
    return mk(0,0,0,0,0,1,0,0,0,2'b00,2'b00,A_AND,1,0);
  endfunction
  function automatic logic [18:0] e_halt();
    return mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,A_AND,0,1);
  endfunction

  task automatic push(input logic [18:0] v, input string n);
    exp_q.push_back(v);
    name_q.push_back(n);
  endtask

  task automatic begin_instr(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op;
    bus.funct  = fn;
    cyc = 0;
    done_q.delete();
    obs_q.delete();
    exp_q.delete();
    name_q.delete();
  endtask

  // Drive one cycle's inputs mid-cycle and record what the DUT shows.
  task automatic run_cycle(input logic rdy, input logic z);
    @(negedge clk);
    bus.mem_ready = rdy;
    bus.zero      = z;
    #1;
    cyc++;
    obs_q.push_back(obs());
    if (bus.instr_done === 1'b1) done_q.push_back(cyc);
  endtask

  // Assert reset between edges, hold it across a rising edge, release
  // between edges; records the outputs at each of those three points.
  task automatic reset_pulse();
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #2 reset = 1'b0;
    #1 obs_q.push_back(obs());
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1 obs_q.push_back(obs());
    #2 reset = 1'b1;
    #1 obs_q.push_back(obs());
  endtask

  task automatic test_reset();
    logic [18:0] e, o;
    string n;
    int first;
    // Power-on: outputs zero while held, then FETCH with mem_read after release
    #1;
    total++;
    if (obs() !== 19'd0) begin
      bad++; $display("FAIL por_hold got=%b want=%b", obs(), 19'd0);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs() !== e_fetch(1'b0)) begin
      bad++; $display("FAIL por_release got=%b want=%b", obs(), e_fetch(1'b0));
    end
    // lw stalled in MEM_READ, then reset mid-stall, then an addi
    begin_instr(6'h23, 6'h00);
    push(e_fetch(1), "lw_fetch"); push(e_decode(), "lw_decode");
    push(e_memaddr(), "lw_addr"); push(e_memread(), "lw_rd0"); push(e_memread(), "lw_rd1");
    run_cycle(1, 0); run_cycle(1, 1); run_cycle(1, 0); run_cycle(0, 1); run_cycle(0, 0);
    push(19'd0, "rst_async"); push(19'd0, "rst_hold"); push(e_fetch(1), "rst_release");
    reset_pulse();
    cyc = 0;
    done_q.delete();
    bus.opcode = 6'h08;
    push(e_fetch(1), "addi_fetch"); push(e_decode(), "addi_decode");
    push(e_addiex(), "addi_ex"); push(e_addiwb(), "addi_wb");
    for (int i = 0; i < 4; i++) run_cycle(1, 1'($urandom_range(0, 1)));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 19'bx;
      total++;
      if (o !== e) begin bad++; $display("FAIL reset/%s got=%b want=%b", n, o, e); end
    end
    first = (done_q.size() > 0) ? done_q[0] : -1;
    total++;
    if (done_q.size() != 1 || first != 4) begin
      bad++; $display("FAIL reset/addi_done_cycle got=%0d (n=%0d) want=4", first, done_q.size());
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [3:0] alus[5] = '{A_ADD, A_SUB, A_AND, A_OR, A_SLT};
    logic [18:0] e, o;
    string n;
    int first;
    for (int k = 0; k < 5; k++) begin
      begin_instr(6'h00, fns[k]);
      push(e_fetch(1), "r_fetch"); push(e_decode(), "r_decode");
      push(e_rexec(alus[k]), "r_exec"); push(e_rwb(), "r_wb");
      for (int i = 0; i < 4; i++) run_cycle(1, 1'($urandom_range(0, 1)));
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); n = name_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 19'bx;
        total++;
        if (o !== e) begin bad++; $display("FAIL rtype_%h/%s got=%b want=%b", fns[k], n, o, e); end
      end
      first = (done_q.size() > 0) ? done_q[0] : -1;
      total++;
      if (done_q.size() != 1 || first != 4) begin
        bad++; $display("FAIL rtype_%h/done_cycle got=%0d want=4", fns[k], first);
      end
    end
  endtask

  task automatic test_lw_stall();
    logic rdy[8] = '{1, 0, 0, 0, 0, 0, 1, 0};
    logic [18:0] e, o;
    string n;
    int first;
    begin_instr(6'h23, 6'h00);
    push(e_fetch(1), "fetch"); push(e_decode(), "decode"); push(e_memaddr(), "addr");
    for (int i = 0; i < 4; i++) push(e_memread(), $sformatf("mem_read%0d", i));
    push(e_memwb(), "mem_wb");
    for (int i = 0; i < 8; i++) run_cycle(rdy[i], 1'($urandom_range(0, 1)));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 19'bx;
      total++;
      if (o !== e) begin bad++; $display("FAIL lw_stall/%s got=%b want=%b", n, o, e); end
    end
    first = (done_q.size() > 0) ? done_q[0] : -1;
    total++;
    if (done_q.size() != 1 || first != 8) begin
      bad++; $display("FAIL lw_stall/done_cycle got=%0d want=8", first);
    end
  endtask

  task automatic test_beq();
    logic zs[3]   = '{1, 0, 1};
    int   stall[3] = '{0, 0, 2};
    logic [18:0] e, o;
    string n;
    int first;
    for (int k = 0; k < 3; k++) begin
      begin_instr(6'h04, 6'h00);
      for (int s = 0; s < stall[k]; s++) push(e_fetch(0), "fetch_stall");
      push(e_fetch(1), "fetch"); push(e_decode(), "decode"); push(e_branch(zs[k]), "branch");
      // zero is driven opposite to the branch value outside BRANCH
      for (int s = 0; s < stall[k]; s++) run_cycle(0, ~zs[k]);
      run_cycle(1, ~zs[k]); run_cycle(0, ~zs[k]); run_cycle(0, zs[k]);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); n = name_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 19'bx;
        total++;
        if (o !== e) begin bad++; $display("FAIL beq%0d/%s got=%b want=%b", k, n, o, e); end
      end
      first = (done_q.size() > 0) ? done_q[0] : -1;
      total++;
      if (done_q.size() != 1 || first != 3 + stall[k]) begin
        bad++; $display("FAIL beq%0d/done_cycle got=%0d want=%0d", k, first, 3 + stall[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int want[3] = '{4, 7, 11};
    logic [18:0] e, o;
    string n;
    int got;
    begin_instr(6'h2B, 6'h00);
    push(e_fetch(1), "sw_fetch"); push(e_decode(), "sw_decode");
    push(e_memaddr(), "sw_addr"); push(e_memwrite(1), "sw_write");
    push(e_fetch(1), "j_fetch"); push(e_decode(), "j_decode"); push(e_jump(), "j_jump");
    push(e_fetch(1), "addi_fetch"); push(e_decode(), "addi_decode");
    push(e_addiex(), "addi_ex"); push(e_addiwb(), "addi_wb");
    for (int i = 0; i < 4; i++) run_cycle(1, 1'($urandom_range(0, 1)));
    bus.opcode = 6'h02;
    for (int i = 0; i < 3; i++) run_cycle(1, 1'($urandom_range(0, 1)));
    bus.opcode = 6'h08;
    for (int i = 0; i < 4; i++) run_cycle(1, 1'($urandom_range(0, 1)));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 19'bx;
      total++;
      if (o !== e) begin bad++; $display("FAIL b2b/%s got=%b want=%b", n, o, e); end
    end
    total++;
    if (done_q.size() != 3) begin
      bad++; $display("FAIL b2b/done_count got=%0d want=3", done_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (done_q.size() > i) ? done_q[i] : -1;
      total++;
      if (got != want[i]) begin
        bad++; $display("FAIL b2b/done%0d got=%0d want=%0d", i, got, want[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops[3] = '{6'h3F, 6'h00, 6'h00};
    logic [5:0] fns[3] = '{6'h00, 6'h00, 6'h08};
    logic [18:0] e, o;
    string n;
    for (int k = 0; k < 3; k++) begin
      begin_instr(ops[k], fns[k]);
      push(e_fetch(1), "fetch"); push(e_decode(), "decode");
      for (int i = 0; i < 20; i++) push(e_halt(), $sformatf("halt%0d", i));
      push(19'd0, "rst_async"); push(19'd0, "rst_hold"); push(e_fetch(1), "rst_release");
      run_cycle(1, 0);
      for (int i = 0; i < 21; i++) run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      reset_pulse();
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); n = name_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 19'bx;
        total++;
        if (o !== e) begin bad++; $display("FAIL illegal%0d/%s got=%b want=%b", k, n, o, e); end
      end
      total++;
      if (done_q.size() != 0) begin
        bad++; $display("FAIL illegal%0d/instr_done_pulses got=%0d want=0", k, done_q.size());
      end
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_beq();
    test_back_to_back();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
